// File: rtl/mux8_word_sequencer.sv
// mux8_word_sequencer: loads a byte over valid/ready and walks the 8:1 mux
// select across it. Ports: clk, rst, in_valid/in_data/in_ready, i0-i7, sel2-0, strobes.
module mux8_word_sequencer #(
  parameter int BIT_DIV   = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       i0,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       i4,
  output logic       i5,
  output logic       i6,
  output logic       i7,
  output logic       sel2,
  output logic       sel1,
  output logic       sel0,
  output logic       bit_valid,
  output logic       first_bit,
  output logic       done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [3:0] DIV_MAX =
    4'(BIT_DIV - 1);
  localparam logic [2:0] SEL_START =
    LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] SEL_END =
    LSB_FIRST ? 3'd7 : 3'd0;

  state_e     state_q, state_d;
  logic [3:0] div_q, div_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] data_q, data_d;

  logic bit_end;
  logic word_end;

  assign bit_end  = (div_q == DIV_MAX);
  assign word_end = (state_q == SHIFT)
                  & bit_end
                  & (sel_q == SEL_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          data_d  = in_data;
          sel_d   = SEL_START;
          div_d   = '0;
        end
      end
      SHIFT: begin
        if (!bit_end) begin
          div_d = div_q + 4'd1;
        end else begin
          div_d = '0;
          if (sel_q != SEL_END) begin
            sel_d = LSB_FIRST
                  ? sel_q + 3'd1
                  : sel_q - 3'd1;
          end else if (in_valid) begin
            // Reload in the done cycle:
            // no idle gap between words.
            data_d = in_data;
            sel_d  = SEL_START;
          end else begin
            state_d = IDLE;
            sel_d   = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) | word_end;
    bit_valid = (state_q == SHIFT);
    // Select only sits at its start value
    // during the first bit of a word.
    first_bit = (state_q == SHIFT)
              & (sel_q == SEL_START);
    done      = word_end;
    {sel2, sel1, sel0} = sel_q;
    {i7, i6, i5, i4, i3, i2, i1, i0} =
      data_q;
  end

endmodule

// File: tb/tb_mux8_word_sequencer.sv
// Bench for mux8_word_sequencer: two configurations
// against a cycle-count reference model.
module tb_mux8_word_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      vld = '0;
  logic [1:0][7:0] din = '0;
  logic [1:0]      rdy, bv, fb, dn;
  logic [1:0][7:0] dout;
  logic [1:0][2:0] sel;

  int errs   = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    mux8_word_sequencer #(
      .BIT_DIV  ((g == 0) ? 1 : 4),
      .LSB_FIRST((g == 0) ? 1'b1 : 1'b0)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld[g]),
      .in_data  (din[g]),
      .in_ready (rdy[g]),
      .i0       (dout[g][0]),
      .i1       (dout[g][1]),
      .i2       (dout[g][2]),
      .i3       (dout[g][3]),
      .i4       (dout[g][4]),
      .i5       (dout[g][5]),
      .i6       (dout[g][6]),
      .i7       (dout[g][7]),
      .sel2     (sel[g][2]),
      .sel1     (sel[g][1]),
      .sel0     (sel[g][0]),
      .bit_valid(bv[g]),
      .first_bit(fb[g]),
      .done     (dn[g])
    );
  end

  // Model: a word is busy for 8*D cycles,
  // t counts cycles since its capture.
  logic       m_busy [2] = '{1'b0, 1'b0};
  int         m_t    [2] = '{0, 0};
  logic [7:0] m_word [2] = '{8'h0, 8'h0};

  function automatic int dv(int g);
    return (g == 0) ? 1 : 4;
  endfunction

  function automatic logic e_last(int g);
    return m_busy[g] && (m_t[g] == 8 * dv(g) - 1);
  endfunction

  function automatic logic [14:0] expv(int g);
    int n;
    logic [2:0] s;
    n = m_t[g] / dv(g);
    s = 3'(g == 0 ? n : 7 - n);
    if (!m_busy[g]) s = 3'd0;
    return {m_word[g], s,
            !m_busy[g] || e_last(g),
            m_busy[g],
            m_busy[g] && (m_t[g] < dv(g)),
            e_last(g)};
  endfunction

  function automatic logic [14:0] obs(int g);
    return {dout[g], sel[g], rdy[g],
            bv[g], fb[g], dn[g]};
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        m_busy[g] <= 1'b0;
        m_t[g]    <= 0;
        m_word[g] <= 8'h0;
      end else if (vld[g] &&
                   (!m_busy[g] || e_last(g))) begin
        m_busy[g] <= 1'b1;
        m_t[g]    <= 0;
        m_word[g] <= din[g];
      end else if (m_busy[g]) begin
        if (e_last(g)) m_busy[g] <= 1'b0;
        else m_t[g] <= m_t[g] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (obs(g) !== expv(g)) begin
        errs++;
        $display("FAIL cycle_cmp[%0d] t=%0t got %h expected %h",
                 g, $time, obs(g), expv(g));
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic send(input int g,
                      input logic [7:0] d);
    int k;
    k = 0;
    vld[g] = 1'b1;
    din[g] = d;
    @(negedge clk);
    while (!rdy[g] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 64'(rdy[g]), 64'd1);
    @(posedge clk);
    #1 vld[g] = 1'b0;
  endtask

  task automatic capture(input int g,
                         input int n,
                         input bit noise,
                         output logic [63:0] y,
                         output logic [63:0] d,
                         output logic [63:0] f,
                         output logic [63:0] r);
    y = '0; d = '0; f = '0; r = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      y[c] = dout[g][sel[g]];
      d[c] = dn[g];
      f[c] = fb[g];
      r[c] = rdy[g];
      if (noise) begin
        if (dn[g]) vld[g] = 1'b0;
        else begin
          vld[g] = 1'($urandom);
          din[g] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++)
      chk("reset_vals", 64'(obs(g)),
          64'({8'h0, 3'b0, 1'b1,
               1'b0, 1'b0, 1'b0}));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [63:0] y, d, f, r;
  logic [63:0] y2, d2, f2, r2;
  logic [63:0] yexp;
  logic [7:0]  yl;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset", 64'(obs(0)),
        64'({8'h0, 3'b0, 1'b1, 3'b0}));

    send(0, 8'h55);
    capture(0, 8, 1'b0, y, d, f, r);
    chk("lsb_y",     y, 64'h55);
    chk("lsb_done",  d, 64'h80);
    chk("lsb_first", f, 64'h01);
    chk("lsb_ready", r, 64'h80);
    @(negedge clk);
    chk("lsb_idle", 64'({sel[0], bv[0], rdy[0]}),
        64'({3'b000, 1'b0, 1'b1}));

    send(1, 8'hA5);
    capture(1, 32, 1'b1, y, d, f, r);
    yl = 8'b1010_0101;
    yexp = '0;
    for (int c = 0; c < 32; c++)
      yexp[c] = yl[7 - c / 4];
    chk("msb_y",     y, yexp);
    chk("msb_done",  d, 64'h8000_0000);
    chk("msb_ready", r, 64'h8000_0000);
    chk("msb_first", f, 64'h0000_000F);

    send(0, 8'hFF);
    vld[0] = 1'b1;
    din[0] = 8'h00;
    capture(0, 8, 1'b0, y, d, f, r);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    capture(0, 8, 1'b0, y2, d2, f2, r2);
    chk("b2b_y1",    y,  64'hFF);
    chk("b2b_done1", d,  64'h80);
    chk("b2b_y2",    y2, 64'h00);
    chk("b2b_first", f2, 64'h01);

    send(0, 8'hC3);
    repeat (2) @(negedge clk);
    mid_reset();
    send(0, 8'h3C);
    capture(0, 8, 1'b0, y, d, f, r);
    chk("rst_y",     y, 64'h3C);
    chk("rst_first", f, 64'h01);
    chk("rst_done",  d, 64'h80);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      vld = 2'($urandom);
      din[0] = 8'($urandom);
      din[1] = 8'($urandom);
      if ($urandom_range(299) == 0)
        mid_reset();
    end
    vld = '0;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/mux8_word_sequencer.md
# mux8_word_sequencer

Upstream driver for the 8:1 multiplexer stage. Accepts an 8-bit parallel word over a valid/ready handshake, presents it on the multiplexer data inputs `i0`–`i7`, and steps the select lines `sel2`/`sel1`/`sel0` through all eight positions, one bit period each. The multiplexer output `y` therefore carries the word as a serial bit stream. Status strobes mark the first bit, valid bit periods and word completion for downstream framing logic.

## Interface
- `BIT_DIV`, default 1: clock cycles each select position is held; legal range 1–16.
- `LSB_FIRST`, default 1: 1 gives select order 0→7; 0 gives select order 7→0.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word available.
- `in_data`  in  8  parallel word; bit n is routed to `in`.
- `in_ready`  out  1  block can accept a word this cycle.
- `i0`…`i7`  out  1 each  captured word bits, wired to the multiplexer data inputs.
- `sel2`, `sel1`, `sel0`  out  1 each  multiplexer select, MSB to LSB.
- `bit_valid`  out  1  the current select position is a live data bit.
- `first_bit`  out  1  high for the whole period of the first bit of a word.
- `done`  out  1  one-cycle pulse in the final cycle of the last bit.

## Operation
- States are IDLE and SHIFT.
- Reset values: state IDLE, `in_ready`=1, `i0`–`i7`=0, `{sel2,sel1,sel0}`=3'b000, `bit_valid`=0, `first_bit`=0, `done`=0, divider and bit counters 0.
- **IDLE**
  - `in_ready`=1 and `bit_valid`=0.
  - A handshake is `in_valid & in_ready` at a rising edge.
  - On a handshake: capture `in_data` into `i0`–`i7`, load select with 0 (LSB_FIRST=1) or 7 (LSB_FIRST=0), clear the divider, set `bit_valid`=1 and `first_bit`=1, enter SHIFT.
- **SHIFT**
  - A divider counts 0..BIT_DIV-1. On its wrap, select advances by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0). Select arithmetic is 3-bit.
  - `first_bit` clears when the select leaves its first position.
  - `i0`–`i7` are stable for the whole SHIFT period.
- **Last-cycle rules** (last select position with divider = BIT_DIV-1):
  - `done`=1 and `in_ready`=1.
  - If `in_valid`=1 in that cycle, the next word is captured at that edge. The block stays in SHIFT with select reloaded to its start value and `first_bit`=1. There is no idle gap between words.
  - Otherwise the block returns to IDLE: `bit_valid`=0, select returns to 3'b000, and `i0`–`i7` hold the last word.
- `in_ready`=0 at all other SHIFT cycles. `in_data` is ignored whenever no handshake occurs.
- Reset asserted mid-word forces all reset values immediately, without waiting for a clock edge. The partial word is discarded. The first handshake after reset release starts a fresh word at its first select position.
- With BIT_DIV=1, the first and last cycles of a bit coincide. `done` and `first_bit` are never high together, because a word always spans 8 cycles.

## Timing
- Handshake at edge k: the new `i0`–`i7`, the first select position, `bit_valid` and `first_bit` are all visible after edge k.
- Bit n of the sequence (n=0..7) occupies cycles k+n·BIT_DIV through k+(n+1)·BIT_DIV−1.
- `done` is high in cycle k+8·BIT_DIV−1.
- A word occupies exactly 8·BIT_DIV cycles. Back-to-back throughput is one word per 8·BIT_DIV cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` or `in_data` to any output except `in_ready`, which depends on state only.

## Test plan
- **Reset values:** assert `rst` mid-cycle → all outputs take their reset values before the next edge; `in_ready`=1.
- **Single word, LSB first:** BIT_DIV=1, LSB_FIRST=1, send 8'b0101_0101 → select goes 0,1,…,7 on consecutive cycles; mux `y`=1,0,1,0,1,0,1,0; `first_bit` only in cycle 0; `done` in cycle 7; then IDLE with select 000.
- **MSB first, slowed bit rate:** BIT_DIV=4, LSB_FIRST=0, send 8'hA5 → select 7..0, each position held 4 cycles; `y`=1,0,1,0,0,1,0,1; `done` at cycle 31; `in_ready`=0 during cycles 0–30.
- **Back-to-back words:** `in_valid` held high with 8'hFF then 8'h00 → the second capture occurs in the `done` cycle; select wraps 7→0 with no gap; `first_bit` reasserts; `y` goes from eight 1s to eight 0s.
- **Reset mid-word:** assert `rst` at bit 3 of 8'hC3, release it, then send 8'h3C → the first word is aborted; the second word starts at select 0 with `first_bit`=1 and streams correctly.
- **Handshake ignored when not ready:** toggle `in_valid` and `in_data` during SHIFT (not in the last cycle) → `i0`–`i7` and the select sequence are unaffected.
